wired_fpu_arb: RTL and testbench

Shares one FPU execution unit (fpnew/cvfpu instance) between two issue queues: requester 0 is the out-of-order FPU issue queue, requester 1 is the in-order FPU/CC issue queue. The block arbitrates requests round-robin and allocates a tag per accepted operation. It registers one request toward the FPU, and routes out-of-order FPU responses back to the owning queue by tag. Flush handling keeps tags of in-flight operations unavailable until their stale responses have drained.

---
 rtl/wired_fpu_arb.sv | 130 +++++++++++++
 tb/tb_wired_fpu_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wired_fpu_arb.sv
// Round-robin arbiter sharing one FPU between the OoO and in-order FP issue queues.
// Tags track in-flight ops so out-of-order responses route back to their owner.
module wired_fpu_arb #(
   parameter int REQ_W   = 128,
   parameter int RESP_W  = 40,
   parameter int TAG_CNT = 4,
   localparam int TAG_W  = $clog2(TAG_CNT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic [1:0]             req_valid_i,
   output logic [1:0]             req_ready_o,
   input  logic [1:0][REQ_W-1:0]  req_payload_i,
   output logic                   fpu_valid_o,
   input  logic                   fpu_ready_i,
   output logic [REQ_W-1:0]       fpu_payload_o,
   output logic [TAG_W-1:0]       fpu_tag_o,
   input  logic                   fpu_resp_valid_i,
   output logic                   fpu_resp_ready_o,
   input  logic [TAG_W-1:0]       fpu_resp_tag_i,
   input  logic [RESP_W-1:0]      fpu_resp_payload_i,
   output logic [1:0]             resp_valid_o,
   input  logic [1:0]             resp_ready_i,
   output logic [RESP_W-1:0]      resp_payload_o,
   output logic [TAG_W:0]         outstanding_o
);

   // Handshakes: a transfer happens in a cycle where valid and ready are both high;
   // valid never depends on ready, and a raised fpu_valid_o holds its payload until taken.

   typedef enum logic [1:0] {
      TAG_FREE  = 2'd0,
      TAG_BUSY  = 2'd1,
      TAG_STALE = 2'd2
   } tag_state_e;

   tag_state_e           tag_q [TAG_CNT];
   tag_state_e           tag_d [TAG_CNT];
   logic [TAG_CNT-1:0]   owner_q, owner_d;
   logic                 rr_q;

   logic                 slot_ready, any_free, grant, winner;
   logic [TAG_W-1:0]     free_idx;
   tag_state_e           rsp_state;
   logic                 rsp_owner, rsp_fire;
   logic [TAG_W:0]       out_cnt_d;

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = TAG_CNT - 1; i >= 0; i--) begin
         if (tag_q[i] == TAG_FREE) begin
            any_free = 1'b1;
            free_idx = TAG_W'(i);
         end
      end
      slot_ready  = !fpu_valid_o || fpu_ready_i;
      grant       = slot_ready && any_free && !flush_i && (|req_valid_i);
      winner      = (&req_valid_i) ? rr_q : req_valid_i[1];
      req_ready_o = '0;
      if (grant) req_ready_o[winner] = 1'b1;
   end

   // Stale and free tags are drained unconditionally; busy tags follow their owner's ready.
   always_comb begin
      rsp_state        = tag_q[fpu_resp_tag_i];
      rsp_owner        = owner_q[fpu_resp_tag_i];
      resp_valid_o     = '0;
      fpu_resp_ready_o = 1'b0;
      if (rsp_state == TAG_BUSY) begin
         if (!flush_i) begin
            resp_valid_o[rsp_owner] = fpu_resp_valid_i;
            fpu_resp_ready_o        = resp_ready_i[rsp_owner];
         end
      end else begin
         fpu_resp_ready_o = 1'b1;
      end
      rsp_fire       = fpu_resp_valid_i && fpu_resp_ready_o;
      resp_payload_o = fpu_resp_payload_i;
   end

   always_comb begin
      tag_d   = tag_q;
      owner_d = owner_q;
      if (rsp_fire) tag_d[fpu_resp_tag_i] = TAG_FREE;
      if (flush_i) begin
         for (int i = 0; i < TAG_CNT; i++) begin
            if (tag_d[i] == TAG_BUSY) tag_d[i] = TAG_STALE;
         end
         // The slot's op never reached the FPU, so no response will come back for it.
         if (fpu_valid_o && !fpu_ready_i) tag_d[fpu_tag_o] = TAG_FREE;
      end else if (grant) begin
         tag_d[free_idx]   = TAG_BUSY;
         owner_d[free_idx] = winner;
      end
      out_cnt_d = '0;
      for (int i = 0; i < TAG_CNT; i++) begin
         if (tag_d[i] != TAG_FREE) out_cnt_d = out_cnt_d + (TAG_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < TAG_CNT; i++) tag_q[i] <= TAG_FREE;
         owner_q       <= '0;
         rr_q          <= 1'b0;
         fpu_valid_o   <= 1'b0;
         fpu_payload_o <= '0;
         fpu_tag_o     <= '0;
         outstanding_o <= '0;
      end else begin
         tag_q         <= tag_d;
         owner_q       <= owner_d;
         outstanding_o <= out_cnt_d;
         if (flush_i) begin
            fpu_valid_o <= 1'b0;
            rr_q        <= 1'b0;
         end else if (grant) begin
            fpu_valid_o   <= 1'b1;
            fpu_payload_o <= req_payload_i[winner];
            fpu_tag_o     <= free_idx;
            rr_q          <= !winner;
         end else if (fpu_ready_i) begin
            fpu_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wired_fpu_arb.sv
// Directed bench for wired_fpu_arb: arbitration, tag allocation, response routing,
// backpressure, slot stall, flush drain and reset recovery.
module tb_wired_fpu_arb;

   localparam int REQ_W   = 128;
   localparam int RESP_W  = 40;
   localparam int TAG_CNT = 4;
   localparam int TAG_W   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush_i;
   logic [1:0]            req_valid_i;
   logic [1:0]            req_ready_o;
   logic [1:0][REQ_W-1:0] req_payload_i;
   logic                  fpu_valid_o;
   logic                  fpu_ready_i;
   logic [REQ_W-1:0]      fpu_payload_o;
   logic [TAG_W-1:0]      fpu_tag_o;
   logic                  fpu_resp_valid_i;
   logic                  fpu_resp_ready_o;
   logic [TAG_W-1:0]      fpu_resp_tag_i;
   logic [RESP_W-1:0]     fpu_resp_payload_i;
   logic [1:0]            resp_valid_o;
   logic [1:0]            resp_ready_i;
   logic [RESP_W-1:0]     resp_payload_o;
   logic [TAG_W:0]        outstanding_o;

   logic [TAG_W+REQ_W-1:0] exp_q[$];
   logic [TAG_W+REQ_W-1:0] saved_slot;
   logic [RESP_W-1:0]      rsp_pay;
   int                     vec_cnt = 0;
   int                     miss_cnt = 0;

   wired_fpu_arb #(.REQ_W(REQ_W), .RESP_W(RESP_W), .TAG_CNT(TAG_CNT)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_payload_i(req_payload_i),
      .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_payload_o(fpu_payload_o),
      .fpu_tag_o(fpu_tag_o), .fpu_resp_valid_i(fpu_resp_valid_i),
      .fpu_resp_ready_o(fpu_resp_ready_o), .fpu_resp_tag_i(fpu_resp_tag_i),
      .fpu_resp_payload_i(fpu_resp_payload_i), .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready_i), .resp_payload_o(resp_payload_o),
      .outstanding_o(outstanding_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic rand_pay();
      req_payload_i[0] = {$urandom, $urandom, $urandom, $urandom};
      req_payload_i[1] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Checks the grant this cycle, then the slot contents after the edge via the queue.
   task automatic grant_cycle(input string name, input logic [1:0] exp_ready,
                              input logic [TAG_W-1:0] exp_tag);
      #1;
      chk({name, "_ready"}, req_ready_o, exp_ready);
      if (exp_ready != 2'b00) exp_q.push_back({exp_tag, req_payload_i[exp_ready[1]]});
      tick();
      if (exp_ready != 2'b00) begin
         chk({name, "_slot_valid"}, fpu_valid_o, 1'b1);
         chk({name, "_slot"}, {fpu_tag_o, fpu_payload_o}, exp_q.pop_front());
      end
   endtask

   task automatic resp_drive(input logic [TAG_W-1:0] t);
      logic [63:0] tmp;
      tmp                = {$urandom, $urandom};
      rsp_pay            = tmp[RESP_W-1:0];
      fpu_resp_valid_i   = 1'b1;
      fpu_resp_tag_i     = t;
      fpu_resp_payload_i = rsp_pay;
   endtask

   task automatic resp_check(input string name, input logic [1:0] exp_valid, input logic exp_ready);
      chk({name, "_rvalid"}, resp_valid_o, exp_valid);
      chk({name, "_rready"}, fpu_resp_ready_o, exp_ready);
      if (exp_valid != 2'b00) chk({name, "_rpayload"}, resp_payload_o, rsp_pay);
   endtask

   task automatic resp_cycle(input string name, input logic [TAG_W-1:0] t,
                             input logic [1:0] exp_valid);
      resp_drive(t);
      #1;
      resp_check(name, exp_valid, 1'b1);
      tick();
      fpu_resp_valid_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 2'b00; fpu_ready_i = 1'b1;
      resp_ready_i = 2'b11; fpu_resp_valid_i = 1'b0; fpu_resp_tag_i = '0;
      fpu_resp_payload_i = '0; rand_pay();
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_fpu_valid", fpu_valid_o, 1'b0);
      chk("rst_outstanding", outstanding_o, 3'd0);
      chk("rst_req_ready", req_ready_o, 2'b00);
      resp_cycle("rst_free_drop", 2'd1, 2'b00);

      // Contention: alternating grants, tags 0..3, stall until tag 0 returns.
      req_valid_i = 2'b11;
      rand_pay(); grant_cycle("cont0", 2'b01, 2'd0);
      rand_pay(); grant_cycle("cont1", 2'b10, 2'd1);
      rand_pay(); grant_cycle("cont2", 2'b01, 2'd2);
      rand_pay(); grant_cycle("cont3", 2'b10, 2'd3);
      rand_pay(); resp_drive(2'd0);
      #1;
      chk("cont_full_outstanding", outstanding_o, 3'd4);
      resp_check("cont_ret0", 2'b01, 1'b1);
      grant_cycle("cont_stall", 2'b00, 2'd0);
      fpu_resp_valid_i = 1'b0;
      chk("cont_slot_empty", fpu_valid_o, 1'b0);
      rand_pay(); grant_cycle("cont4", 2'b01, 2'd0);
      req_valid_i = 2'b00;

      // Out-of-order return, then response backpressure on owner 1.
      resp_cycle("ooo_t1", 2'd1, 2'b10);
      resp_cycle("ooo_t0", 2'd0, 2'b01);
      chk("ooo_outstanding", outstanding_o, 3'd2);
      resp_ready_i = 2'b01;
      resp_drive(2'd3);
      for (int i = 0; i < 3; i++) begin
         #1;
         resp_check("bp_hold", 2'b10, 1'b0);
         tick();
         chk("bp_outstanding", outstanding_o, 3'd2);
      end
      resp_ready_i = 2'b11;
      #1;
      resp_check("bp_release", 2'b10, 1'b1);
      tick();
      fpu_resp_valid_i = 1'b0;
      chk("bp_freed", outstanding_o, 3'd1);
      resp_cycle("bp_t2", 2'd2, 2'b01);
      chk("drain_outstanding", outstanding_o, 3'd0);

      // Tag exhaustion: freed tag is reused on the following cycle only.
      req_valid_i = 2'b01;
      for (int i = 0; i < TAG_CNT; i++) begin
         rand_pay(); grant_cycle("exh_fill", 2'b01, TAG_W'(i));
      end
      rand_pay(); resp_drive(2'd2);
      #1;
      chk("exh_outstanding", outstanding_o, 3'd4);
      resp_check("exh_ret2", 2'b01, 1'b1);
      grant_cycle("exh_same_cycle", 2'b00, 2'd0);
      fpu_resp_valid_i = 1'b0;
      rand_pay(); grant_cycle("exh_regrant", 2'b01, 2'd2);
      req_valid_i = 2'b00;
      resp_cycle("exh_d0", 2'd0, 2'b01);
      resp_cycle("exh_d1", 2'd1, 2'b01);
      resp_cycle("exh_d3", 2'd3, 2'b01);
      resp_cycle("exh_d2", 2'd2, 2'b01);
      chk("exh_drained", outstanding_o, 3'd0);

      // Slot stall: held payload/tag for 5 cycles, then grant on the rising ready.
      fpu_ready_i = 1'b0; req_valid_i = 2'b01; rand_pay();
      saved_slot = {2'd0, req_payload_i[0]};
      grant_cycle("stall_load", 2'b01, 2'd0);
      req_valid_i = 2'b11;
      for (int i = 0; i < 5; i++) begin
         rand_pay();
         #1;
         chk("stall_ready", req_ready_o, 2'b00);
         chk("stall_valid", fpu_valid_o, 1'b1);
         chk("stall_slot", {fpu_tag_o, fpu_payload_o}, saved_slot);
         tick();
      end
      fpu_ready_i = 1'b1; rand_pay();
      grant_cycle("stall_release", 2'b10, 2'd1);

      // Flush: tags 0,1 accepted, tag 2 stuck in slot.
      req_valid_i = 2'b01; rand_pay();
      grant_cycle("fl_setup", 2'b01, 2'd2);
      fpu_ready_i = 1'b0; req_valid_i = 2'b11; flush_i = 1'b1;
      #1;
      chk("fl_no_grant", req_ready_o, 2'b00);
      tick();
      flush_i = 1'b0;
      chk("fl_slot_empty", fpu_valid_o, 1'b0);
      chk("fl_outstanding", outstanding_o, 3'd2);
      fpu_ready_i = 1'b1; rand_pay(); resp_drive(2'd0);
      #1;
      resp_check("fl_drop0", 2'b00, 1'b1);
      grant_cycle("fl_regrant", 2'b01, 2'd2);
      fpu_resp_valid_i = 1'b0; req_valid_i = 2'b00;
      chk("fl_outstanding2", outstanding_o, 3'd2);
      resp_cycle("fl_drop1", 2'd1, 2'b00);
      chk("fl_outstanding1", outstanding_o, 3'd1);
      resp_cycle("fl_t2", 2'd2, 2'b01);
      chk("fl_outstanding0", outstanding_o, 3'd0);

      // Reset with flush mid-operation: reset wins, pointer back to 0.
      req_valid_i = 2'b10; rand_pay();
      grant_cycle("rst_grant", 2'b10, 2'd0);
      req_valid_i = 2'b00; flush_i = 1'b1; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; flush_i = 1'b0;
      chk("rst2_outstanding", outstanding_o, 3'd0);
      chk("rst2_fpu_valid", fpu_valid_o, 1'b0);
      resp_cycle("rst2_drop", 2'd0, 2'b00);
      req_valid_i = 2'b11; rand_pay();
      grant_cycle("rst2_ptr", 2'b01, 2'd0);
      req_valid_i = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
